// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/decode/execute controller for an 8-bit, 32-entry
// register file. Each instruction walks FETCH -> RF -> EX -> WB. A halt instruction
// diverts to OUTPUT, where r5 is captured once the register file raises done, and then
// parks in HALT until reset.
//
// Optional feature: define INSTR_SEQ_ADDI_EN to decode opcode 0x08 as addi
// (rd = ir[20:16], result = rsv + imm[7:0]). Without it, 0x08 is an invalid opcode and
// the immediate datapath is not built.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   instr_req            fetch request, high in FETCH while out of reset
//   instr_addr           program counter
//   instr_valid/data     fetch response, accepted only in FETCH
//   state                shared state bus (FETCH=0 RF=1 EX=2 WB=3 OUTPUT=4 HALT=5)
//   rs, rt, rd           register-file indices decoded from the held instruction
//   result               registered ALU result, written back during WB
//   instruction_invalid  held instruction cannot be decoded; WB writes nothing
//   rsv, rtv             operand values returned by the register file
//   done                 register file has presented the output register
//   out_value            r5 captured at program completion
//   halted               program complete
//   instr_count          retired valid instructions, saturating at 255
module instr_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    output logic        instr_req,
    output logic [7:0]  instr_addr,
    input  logic        instr_valid,
    input  logic [31:0] instr_data,
    output logic [2:0]  state,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [7:0]  result,
    output logic        instruction_invalid,
    input  logic [7:0]  rsv,
    input  logic [7:0]  rtv,
    input  logic        done,
    output logic [7:0]  out_value,
    output logic        halted,
    output logic [7:0]  instr_count
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StRf     = 3'd1,
        StEx     = 3'd2,
        StWb     = 3'd3,
        StOutput = 3'd4,
        StHalt   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        AluNone,
        AluAdd,
        AluSub,
        AluAnd,
        AluOr,
        AluSlt,
        AluAddi
    } alu_op_e;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpHalt  = 6'h3F;
`ifdef INSTR_SEQ_ADDI_EN
    localparam logic [5:0] OpAddi  = 6'h08;
`endif
    localparam logic [5:0] FnAdd   = 6'h20;
    localparam logic [5:0] FnSub   = 6'h22;
    localparam logic [5:0] FnAnd   = 6'h24;
    localparam logic [5:0] FnOr    = 6'h25;
    localparam logic [5:0] FnSlt   = 6'h2A;

    // Register file slot captured as the program's output value.
    localparam logic [4:0] OutReg  = 5'd5;

    state_e      state_q;
    logic [7:0]  pc_q;
    logic [31:0] ir_q;
    logic [7:0]  result_q;
    logic [7:0]  out_value_q;
    logic        halted_q;
    logic [7:0]  count_q;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    alu_op_e     alu_op;
    logic        invalid;
    logic [4:0]  rd_dec;
    logic [7:0]  alu_res;

    assign opcode = ir_q[31:26];
    assign funct  = ir_q[5:0];

    // Decode is purely a function of the held instruction word.
    always_comb begin
        alu_op  = AluNone;
        invalid = 1'b0;
        rd_dec  = 5'd0;
        case (opcode)
            OpRtype: begin
                rd_dec = ir_q[15:11];
                case (funct)
                    FnAdd:   alu_op = AluAdd;
                    FnSub:   alu_op = AluSub;
                    FnAnd:   alu_op = AluAnd;
                    FnOr:    alu_op = AluOr;
                    FnSlt:   alu_op = AluSlt;
                    default: begin
                        // The all-zero word (reset contents of ir) is a harmless
                        // valid no-op targeting r0; any other unknown funct is invalid.
                        if (ir_q != 32'd0) begin
                            invalid = 1'b1;
                            rd_dec  = 5'd0;
                        end
                    end
                endcase
            end
`ifdef INSTR_SEQ_ADDI_EN
            OpAddi: begin
                alu_op = AluAddi;
                rd_dec = ir_q[20:16];
            end
`endif
            OpHalt: begin
                alu_op = AluNone;
            end
            default: begin
                invalid = 1'b1;
            end
        endcase
    end

    always_comb begin
        alu_res = 8'd0;
        case (alu_op)
            AluAdd:  alu_res = rsv + rtv;
            AluSub:  alu_res = rsv - rtv;
            AluAnd:  alu_res = rsv & rtv;
            AluOr:   alu_res = rsv | rtv;
            AluSlt:  alu_res = {7'd0, ($signed(rsv) < $signed(rtv))};
`ifdef INSTR_SEQ_ADDI_EN
            AluAddi: alu_res = rsv + ir_q[7:0];
`endif
            default: alu_res = 8'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StFetch;
            pc_q        <= 8'd0;
            ir_q        <= 32'd0;
            result_q    <= 8'd0;
            out_value_q <= 8'd0;
            halted_q    <= 1'b0;
            count_q     <= 8'd0;
        end else begin
            case (state_q)
                StFetch: begin
                    if (instr_valid) begin
                        ir_q    <= instr_data;
                        state_q <= (instr_data[31:26] == OpHalt) ? StOutput : StRf;
                    end
                end
                StRf: begin
                    state_q <= StEx;
                end
                StEx: begin
                    result_q <= alu_res;
                    state_q  <= StWb;
                end
                StWb: begin
                    pc_q <= pc_q + 8'd1;
                    if (!invalid && (count_q != 8'hFF)) begin
                        count_q <= count_q + 8'd1;
                    end
                    state_q <= StFetch;
                end
                StOutput: begin
                    if (done) begin
                        out_value_q <= rsv;
                        halted_q    <= 1'b1;
                        state_q     <= StHalt;
                    end
                end
                StHalt: begin
                    state_q <= StHalt;
                end
                default: begin
                    state_q <= StFetch;
                end
            endcase
        end
    end

    assign instr_req           = (state_q == StFetch) && rst_n;
    assign instr_addr          = pc_q;
    assign state               = state_q;
    // Once halting, point the read port at the output register.
    assign rs                  = ((state_q == StOutput) || (state_q == StHalt)) ? OutReg
                                                                                : ir_q[25:21];
    assign rt                  = ir_q[20:16];
    assign rd                  = rd_dec;
    assign result              = result_q;
    assign instruction_invalid = invalid;
    assign out_value           = out_value_q;
    assign halted              = halted_q;
    assign instr_count         = count_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: instruction memory and register-file models drive the DUT;
// expected write-backs and halt results are queued by the stimulus and consumed by a
// monitor whenever the DUT reaches WB or raises halted.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_req;
    logic [7:0]  instr_addr;
    logic        instr_valid = 1'b0;
    logic [31:0] instr_data = 32'd0;
    logic [2:0]  state;
    logic [4:0]  rs, rt, rd;
    logic [7:0]  result;
    logic        instruction_invalid;
    logic [7:0]  rsv = 8'd0;
    logic [7:0]  rtv = 8'd0;
    logic        done = 1'b0;
    logic [7:0]  out_value;
    logic        halted;
    logic [7:0]  instr_count;

    instr_sequencer dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .instr_req           (instr_req),
        .instr_addr          (instr_addr),
        .instr_valid         (instr_valid),
        .instr_data          (instr_data),
        .state               (state),
        .rs                  (rs),
        .rt                  (rt),
        .rd                  (rd),
        .result              (result),
        .instruction_invalid (instruction_invalid),
        .rsv                 (rsv),
        .rtv                 (rtv),
        .done                (done),
        .out_value           (out_value),
        .halted              (halted),
        .instr_count         (instr_count)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] HaltW = 32'hFC00_0000;
    localparam logic [31:0] NopW  = 32'h0000_0020;   // add r0,r0,r0
    localparam logic [5:0]  FAdd  = 6'h20;
    localparam logic [5:0]  FSub  = 6'h22;
    localparam logic [5:0]  FAnd  = 6'h24;
    localparam logic [5:0]  FOr   = 6'h25;
    localparam logic [5:0]  FSlt  = 6'h2A;

    int checks = 0;
    int failures = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] rt_w(logic [4:0] s, logic [4:0] t, logic [4:0] d,
                                         logic [5:0] f);
        return {6'h00, s, t, d, 5'h00, f};
    endfunction

    function automatic logic [31:0] it_w(logic [5:0] op, logic [4:0] s, logic [4:0] t,
                                         logic [7:0] imm);
        return {op, s, t, 8'h00, imm};
    endfunction

    // Scoreboard queues: written only by stimulus, read in order by the monitor.
    typedef struct {
        logic [7:0] pc;
        logic [4:0] rd;
        logic       inv;
        logic [7:0] res;
        int         gap;    // expected cycles since previous WB; 0 = not checked
    } wb_t;
    typedef struct {
        logic [7:0] out;
        logic [7:0] cnt;
        logic [7:0] pc;
    } halt_t;

    wb_t   wb_q[$];
    halt_t halt_q[$];
    int    wb_idx = 0;
    int    halt_idx = 0;

    function automatic void push_wb(logic [7:0] pc, logic [4:0] d, logic inv, logic [7:0] res,
                                    int gap);
        wb_t e;
        e.pc = pc; e.rd = d; e.inv = inv; e.res = res; e.gap = gap;
        wb_q.push_back(e);
    endfunction

    function automatic void push_halt(logic [7:0] out, logic [7:0] cnt, logic [7:0] pc);
        halt_t e;
        e.out = out; e.cnt = cnt; e.pc = pc;
        halt_q.push_back(e);
    endfunction

    // Stimulus-owned environment settings.
    logic [31:0] rom[256];
    logic [7:0]  rf_init[32];
    int          stall = 0;
    int          fetch_lim = 1000;
    logic        noise = 1'b0;

    // Instruction memory: answers after `stall` idle cycles; with `noise` set it also
    // waves a halt word with instr_valid high while no fetch is pending.
    int wcnt = 0;
    int fetch_n = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            wcnt = 0;
            fetch_n = 0;
            instr_valid = 1'b0;
            instr_data = 32'd0;
        end else if (instr_req) begin
            if (wcnt >= stall) begin
                instr_valid = 1'b1;
                instr_data = (fetch_n >= fetch_lim) ? HaltW : rom[instr_addr];
                wcnt = 0;
                fetch_n++;
            end else begin
                instr_valid = 1'b0;
                wcnt++;
            end
        end else begin
            instr_valid = noise;
            instr_data = HaltW;
        end
    end

    // Register file model, acting on the state sampled before each edge.
    logic [7:0] rf[32];
    logic [2:0] st_s = 3'd0;
    logic [4:0] rs_s = 5'd0, rt_s = 5'd0, rd_s = 5'd0;
    logic       inv_s = 1'b0;
    logic [7:0] res_s = 8'd0;
    always @(negedge clk) begin
        st_s = state; rs_s = rs; rt_s = rt; rd_s = rd; inv_s = instruction_invalid;
        res_s = result;
    end
    always @(posedge clk) begin
        if (!rst_n) begin
            rf = rf_init;
            rsv = 8'd0;
            rtv = 8'd0;
            done = 1'b0;
        end else begin
            case (st_s)
                3'd1: begin
                    #1;
                    rsv = rf[rs_s];
                    rtv = rf[rt_s];
                end
                3'd3: begin
                    if (!inv_s && rd_s != 5'd0) rf[rd_s] = res_s;
                    done = 1'b0;
                end
                3'd4: begin
                    #1;
                    rsv = rf[5];
                    done = 1'b1;
                end
                default: done = 1'b0;
            endcase
        end
    end

    // Monitor.
    int    cyc = 0;
    int    last_wb = 0;
    int    out_cnt = 0;
    logic  halt_seen = 1'b0;
    wb_t   ew;
    halt_t eh;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (!rst_n) begin
            halt_seen = 1'b0;
            out_cnt = 0;
        end else begin
            if (state == 3'd0) chk("fetch_req", {31'd0, instr_req}, 32'd1);
            if (state == 3'd4) out_cnt++;
            if (state == 3'd3) begin
                chk("wb_expected", {31'd0, wb_idx < wb_q.size()}, 32'd1);
                if (wb_idx < wb_q.size()) begin
                    ew = wb_q[wb_idx];
                    wb_idx++;
                    chk("wb_pc", {24'd0, instr_addr}, {24'd0, ew.pc});
                    chk("wb_rd", {27'd0, rd}, {27'd0, ew.rd});
                    chk("wb_invalid", {31'd0, instruction_invalid}, {31'd0, ew.inv});
                    if (!ew.inv) chk("wb_result", {24'd0, result}, {24'd0, ew.res});
                    if (ew.gap > 0) chk("wb_latency", cyc - last_wb, ew.gap);
                end
                last_wb = cyc;
            end
            if (halted && !halt_seen) begin
                halt_seen = 1'b1;
                chk("halt_expected", {31'd0, halt_idx < halt_q.size()}, 32'd1);
                if (halt_idx < halt_q.size()) begin
                    eh = halt_q[halt_idx];
                    halt_idx++;
                    chk("out_value", {24'd0, out_value}, {24'd0, eh.out});
                    chk("instr_count", {24'd0, instr_count}, {24'd0, eh.cnt});
                    chk("halt_pc", {24'd0, instr_addr}, {24'd0, eh.pc});
                    chk("halt_state", {29'd0, state}, 32'd5);
                    chk("halt_req", {31'd0, instr_req}, 32'd0);
                    chk("output_cycles", out_cnt, 2);
                end
            end
        end
    end

    task automatic check_reset();
        chk("rst_state", {29'd0, state}, 32'd0);
        chk("rst_addr", {24'd0, instr_addr}, 32'd0);
        chk("rst_rs", {27'd0, rs}, 32'd0);
        chk("rst_rt", {27'd0, rt}, 32'd0);
        chk("rst_rd", {27'd0, rd}, 32'd0);
        chk("rst_result", {24'd0, result}, 32'd0);
        chk("rst_invalid", {31'd0, instruction_invalid}, 32'd0);
        chk("rst_out_value", {24'd0, out_value}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_count", {24'd0, instr_count}, 32'd0);
        chk("rst_req", {31'd0, instr_req}, 32'd0);
    endtask

    task automatic begin_test(input int stall_n, input logic noise_n);
        @(negedge clk);
        #1 rst_n = 1'b0;
        stall = stall_n;
        noise = noise_n;
        fetch_lim = 1000;
        for (int i = 0; i < 256; i++) rom[i] = HaltW;
        for (int i = 0; i < 32; i++) rf_init[i] = 8'd0;
    endtask

    task automatic start();
        repeat (2) @(posedge clk);
        #1 check_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic wait_halt(input int budget);
        for (int i = 0; i < budget && !halt_seen; i++) @(negedge clk);
        #1;
        chk("halt_timeout", {31'd0, halt_seen}, 32'd1);
        chk("wb_left", wb_q.size() - wb_idx, 32'd0);
        chk("halt_left", halt_q.size() - halt_idx, 32'd0);
        repeat (3) @(negedge clk);
        #1 chk("halt_hold", {29'd0, state}, 32'd5);
    endtask

    initial begin
        // add/sub chain, zero-wait memory
        begin_test(0, 1'b0);
        rf_init[1] = 8'd7; rf_init[2] = 8'd5;
        rom[0] = rt_w(5'd1, 5'd2, 5'd3, FAdd);
        rom[1] = rt_w(5'd1, 5'd2, 5'd4, FSub);
        rom[2] = rt_w(5'd3, 5'd4, 5'd5, FAdd);
        push_wb(8'd0, 5'd3, 1'b0, 8'd12, 0);
        push_wb(8'd1, 5'd4, 1'b0, 8'd2, 4);
        push_wb(8'd2, 5'd5, 1'b0, 8'd14, 4);
        push_halt(8'd14, 8'd3, 8'd3);
        start();
        wait_halt(100);

        // sub wrap and signed slt, with stray instr_valid outside FETCH
        begin_test(0, 1'b1);
        rf_init[1] = 8'd3; rf_init[2] = 8'd5; rf_init[6] = 8'h80; rf_init[7] = 8'd1;
        rom[0] = rt_w(5'd1, 5'd2, 5'd5, FSub);
        rom[1] = rt_w(5'd6, 5'd7, 5'd3, FSlt);
        rom[2] = rt_w(5'd7, 5'd6, 5'd4, FSlt);
        push_wb(8'd0, 5'd5, 1'b0, 8'd254, 0);
        push_wb(8'd1, 5'd3, 1'b0, 8'd1, 4);
        push_wb(8'd2, 5'd4, 1'b0, 8'd0, 4);
        push_halt(8'd254, 8'd3, 8'd3);
        start();
        wait_halt(100);

        // and / or / slt with a negative operand
        begin_test(0, 1'b0);
        rf_init[1] = 8'hF0; rf_init[2] = 8'h3C;
        rom[0] = rt_w(5'd1, 5'd2, 5'd3, FAnd);
        rom[1] = rt_w(5'd1, 5'd2, 5'd4, FOr);
        rom[2] = rt_w(5'd1, 5'd2, 5'd5, FSlt);
        push_wb(8'd0, 5'd3, 1'b0, 8'h30, 0);
        push_wb(8'd1, 5'd4, 1'b0, 8'hFC, 4);
        push_wb(8'd2, 5'd5, 1'b0, 8'd1, 4);
        push_halt(8'd1, 8'd3, 8'd3);
        start();
        wait_halt(100);

        // invalid opcode and invalid funct still advance pc, do not count
        begin_test(0, 1'b0);
        rf_init[1] = 8'd9; rf_init[5] = 8'h55;
        rom[0] = {6'h11, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20};
        rom[1] = rt_w(5'd1, 5'd1, 5'd5, 6'h21);
        rom[2] = rt_w(5'd1, 5'd0, 5'd5, FAdd);
        push_wb(8'd0, 5'd0, 1'b1, 8'd0, 0);
        push_wb(8'd1, 5'd0, 1'b1, 8'd0, 4);
        push_wb(8'd2, 5'd5, 1'b0, 8'd9, 4);
        push_halt(8'd9, 8'd1, 8'd3);
        start();
        wait_halt(100);

        // three-cycle memory stall on every fetch
        begin_test(3, 1'b0);
        rf_init[1] = 8'd4; rf_init[2] = 8'd6;
        rom[0] = rt_w(5'd1, 5'd2, 5'd5, FAdd);
        rom[1] = rt_w(5'd5, 5'd1, 5'd5, FAdd);
        push_wb(8'd0, 5'd5, 1'b0, 8'd10, 0);
        push_wb(8'd1, 5'd5, 1'b0, 8'd14, 7);
        push_halt(8'd14, 8'd2, 8'd2);
        start();
        wait_halt(100);

        // asynchronous reset during EX of the second instruction, then rerun
        begin_test(0, 1'b0);
        rf_init[1] = 8'd2; rf_init[2] = 8'd3; rf_init[5] = 8'h77;
        rom[0] = rt_w(5'd1, 5'd2, 5'd3, FAdd);
        rom[1] = rt_w(5'd1, 5'd1, 5'd4, FAdd);
        push_wb(8'd0, 5'd3, 1'b0, 8'd5, 0);
        start();
        for (int i = 0; i < 40 && wb_idx < wb_q.size(); i++) @(negedge clk);
        for (int i = 0; i < 40 && state != 3'd2; i++) @(negedge clk);
        chk("ex_reached", {29'd0, state}, 32'd2);
        #1 rst_n = 1'b0;
        #1 check_reset();
        push_wb(8'd0, 5'd3, 1'b0, 8'd5, 0);
        push_wb(8'd1, 5'd4, 1'b0, 8'd4, 4);
        push_halt(8'h77, 8'd2, 8'd2);
        start();
        wait_halt(100);

        // addi: decoded only when the immediate option is built
        begin_test(0, 1'b0);
        rf_init[1] = 8'hFB;
        rom[0] = it_w(6'h08, 5'd1, 5'd6, 8'h08);
        rom[1] = it_w(6'h08, 5'd0, 5'd5, 8'h09);
`ifdef INSTR_SEQ_ADDI_EN
        push_wb(8'd0, 5'd6, 1'b0, 8'h03, 0);
        push_wb(8'd1, 5'd5, 1'b0, 8'h09, 4);
        push_halt(8'd9, 8'd2, 8'd2);
`else
        push_wb(8'd0, 5'd0, 1'b1, 8'h00, 0);
        push_wb(8'd1, 5'd0, 1'b1, 8'h00, 4);
        push_halt(8'd0, 8'd0, 8'd2);
`endif
        start();
        wait_halt(100);

        // 260 no-ops: pc wraps 255->0 and instr_count saturates at 255
        begin_test(0, 1'b0);
        rf_init[5] = 8'h5A;
        for (int i = 0; i < 256; i++) rom[i] = NopW;
        fetch_lim = 260;
        for (int i = 0; i < 260; i++) begin
            push_wb(8'(i), 5'd0, 1'b0, 8'd0, (i == 0) ? 0 : 4);
        end
        push_halt(8'h5A, 8'd255, 8'd4);
        start();
        wait_halt(1200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
